router_ctrl_fsm: RTL and testbench

Packet-sequencing controller for the 1x3 router.
- Decodes the 2-bit destination in each header byte and sequences writes into one of three 16x9 output FIFOs.
- Generates the FIFO load-state strobes (lfd/ld/laf/full) and back-pressures the source via busy.
- Owns the per-port read-timeout that issues soft resets to stalled output FIFOs.

---
 rtl/router_pkg.sv | 49 ++++
 rtl/router_soft_rst_timer.sv | 38 +++
 rtl/router_ctrl_fsm.sv | 173 +++++++++++++++++
 tb/tb_router_ctrl_fsm.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet controller.
// The optional DROP_PACKET path is enabled by ROUTER_ADDR_ERR_EN in router_ctrl_fsm.
package router_pkg;

    localparam int ADDR_W      = 2;
    localparam int NUM_PORTS   = 3;
    localparam int DEF_TIMEOUT = 30;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        WAIT_TILL_EMPTY    = 4'd1,
        LOAD_FIRST_DATA    = 4'd2,
        LOAD_DATA          = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_AFTER_FULL    = 4'd5,
        LOAD_PARITY        = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP_PACKET        = 4'd8
    } router_state_t;

    // Per-port bit select that stays defined for the unused address 3.
    function automatic logic sel_port(input logic [NUM_PORTS-1:0] vec,
                                      input logic [ADDR_W-1:0]    addr);
        logic bit_sel;
        bit_sel = 1'b0;
        case (addr)
            2'd0:    bit_sel = vec[0];
            2'd1:    bit_sel = vec[1];
            2'd2:    bit_sel = vec[2];
            default: bit_sel = 1'b0;
        endcase
        return bit_sel;
    endfunction

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_PORTS-1:0] oh;
        oh = '0;
        case (addr)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/router_soft_rst_timer.sv
// Per-port read timeout: pulses soft_rst for one cycle after TIMEOUT
// consecutive cycles of valid data that nobody reads.
module router_soft_rst_timer #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic read_en,
    output logic soft_rst
);

    logic [CNT_W-1:0] count;
    logic             stalled;

    assign stalled = vld & ~read_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= '0;
            soft_rst <= 1'b0;
        end else begin
            soft_rst <= 1'b0;
            if (stalled) begin
                if (count == CNT_W'(TIMEOUT - 1)) begin
                    soft_rst <= 1'b1;
                    count    <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/router_ctrl_fsm.sv
// Packet-sequencing controller for the 1x3 router: header decode, FIFO load
// strobes, source back-pressure and per-port read timeouts. Define
// ROUTER_ADDR_ERR_EN to drop packets addressed to port 3 and report addr_err.
module router_ctrl_fsm
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [7:0]           data_in,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] read_en,
    output logic [NUM_PORTS-1:0] we,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] vld_out,
`ifdef ROUTER_ADDR_ERR_EN
    output logic                 addr_err,
`endif
    output logic [NUM_PORTS-1:0] soft_rst
);

    router_state_t     state;
    router_state_t     next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] hdr_addr;
    logic              hdr_ok;
    logic              write_state;
    logic              unused_payload;

    assign hdr_addr       = data_in[ADDR_W-1:0];
    assign hdr_ok         = pkt_valid && (hdr_addr != ADDR_INVALID);
    assign unused_payload = ^data_in[7:ADDR_W];
    assign vld_out        = ~fifo_empty;

    // A soft reset on the port we are filling aborts the packet from any state.
    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (hdr_ok) begin
                    next_state = sel_port(fifo_empty, hdr_addr) ? LOAD_FIRST_DATA
                                                                : WAIT_TILL_EMPTY;
                end
`ifdef ROUTER_ADDR_ERR_EN
                else if (pkt_valid) begin
                    next_state = DROP_PACKET;
                end
`endif
            end
            WAIT_TILL_EMPTY: begin
                if (sel_port(fifo_empty, addr_q)) next_state = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (sel_port(fifo_full, addr_q)) next_state = FIFO_FULL_STATE;
                else if (!pkt_valid)             next_state = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!sel_port(fifo_full, addr_q)) next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        next_state = DECODE_ADDRESS;
                else if (low_pkt_valid) next_state = LOAD_PARITY;
                else                    next_state = LOAD_DATA;
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                next_state = sel_port(fifo_full, addr_q) ? FIFO_FULL_STATE
                                                         : DECODE_ADDRESS;
            end
`ifdef ROUTER_ADDR_ERR_EN
            DROP_PACKET: begin
                if (!pkt_valid) next_state = DECODE_ADDRESS;
            end
`endif
            default: next_state = DECODE_ADDRESS;
        endcase

        if (state != DECODE_ADDRESS && sel_port(soft_rst, addr_q)) begin
            next_state = DECODE_ADDRESS;
        end
    end

    always_comb begin
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        rst_int_reg = 1'b0;
        busy        = 1'b1;
        write_state = 1'b0;
        case (state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
            LOAD_FIRST_DATA: begin
                lfd_state   = 1'b1;
                write_state = 1'b1;
            end
            LOAD_DATA: begin
                ld_state    = 1'b1;
                busy        = 1'b0;
                write_state = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state   = 1'b1;
                write_state = 1'b1;
            end
            FIFO_FULL_STATE:    full_state  = 1'b1;
            LOAD_PARITY:        write_state = 1'b1;
            CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
`ifdef ROUTER_ADDR_ERR_EN
            DROP_PACKET:        busy        = 1'b0;
`endif
            default: ;
        endcase

        we = '0;
        if (write_state && !sel_port(fifo_full, addr_q)) begin
            we = port_onehot(addr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= DECODE_ADDRESS;
            addr_q <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && hdr_ok) begin
                addr_q <= hdr_addr;
            end
        end
    end

`ifdef ROUTER_ADDR_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= (state != DROP_PACKET) && (next_state == DROP_PACKET);
        end
    end
`endif

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
        router_soft_rst_timer #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_timer (
            .clk      (clk),
            .rst      (rst),
            .vld      (vld_out[i]),
            .read_en  (read_en[i]),
            .soft_rst (soft_rst[i])
        );
    end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed scoreboard bench for router_ctrl_fsm; honours ROUTER_ADDR_ERR_EN.
module tb_router_ctrl_fsm;

    localparam int S_DA   = 0;
    localparam int S_WTE  = 1;
    localparam int S_LFD  = 2;
    localparam int S_LD   = 3;
    localparam int S_FULL = 4;
    localparam int S_LAF  = 5;
    localparam int S_LP   = 6;
    localparam int S_CPE  = 7;
    localparam int S_DROP = 8;

    typedef struct {
        string       tag;
        logic [16:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic [2:0] fifo_full = 3'b000;
    logic [2:0] fifo_empty = 3'b111;
    logic [2:0] read_en = 3'b000;
    logic [2:0] we, vld_out, soft_rst;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy;
    logic       ae_obs;
    logic [16:0] obs;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    router_ctrl_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .read_en       (read_en),
        .we            (we),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy),
        .vld_out       (vld_out),
`ifdef ROUTER_ADDR_ERR_EN
        .addr_err      (ae_obs),
`endif
        .soft_rst      (soft_rst)
    );

`ifndef ROUTER_ADDR_ERR_EN
    assign ae_obs = 1'b0;
`endif

    assign obs = {ae_obs, we, detect_add, lfd_state, ld_state, laf_state, full_state,
                  rst_int_reg, busy, soft_rst, vld_out};

    // Expected output vector built from the state name the bench believes the FSM is in.
    function automatic logic [16:0] ev(input int st, input logic [2:0] w,
                                       input logic [2:0] sr, input logic [2:0] vld,
                                       input logic ae = 1'b0);
        logic bsy;
        bsy = !(st == S_DA || st == S_LD || st == S_DROP);
        return {ae, w, logic'(st == S_DA), logic'(st == S_LFD), logic'(st == S_LD),
                logic'(st == S_LAF), logic'(st == S_FULL), logic'(st == S_CPE),
                bsy, sr, vld};
    endfunction

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_empty observed=%b expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            assert (obs === e.v) else begin
                n_fail++;
                $display("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
                $error("[TB] step %s differs", e.tag);
            end
        end
    endtask

    // Drive one cycle of inputs just after the edge, then check at the falling edge.
    task automatic applyStimulus(input string tag, input logic r, input logic pv,
                                 input logic [7:0] d, input logic [2:0] ff,
                                 input logic [2:0] fe, input logic [2:0] re,
                                 input logic [16:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        rst        = r;
        pkt_valid  = pv;
        data_in    = d;
        fifo_full  = ff;
        fifo_empty = fe;
        read_en    = re;
        x.tag = tag;
        x.v   = e;
        sb.push_back(x);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        $display("[TB] start");

        applyStimulus("reset_0", 0, 0, 8'h00, 3'b000, 3'b101, 3'b000, ev(S_DA, 3'b000, 3'b000, 3'b010));
        applyStimulus("reset_1", 0, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_DA, 3'b000, 3'b000, 3'b000));

        applyStimulus("p1_hdr",  1, 1, 8'h0D, 3'b000, 3'b111, 3'b000, ev(S_DA,  3'b000, 3'b000, 3'b000));
        applyStimulus("p1_lfd",  1, 1, 8'h11, 3'b000, 3'b111, 3'b000, ev(S_LFD, 3'b010, 3'b000, 3'b000));
        applyStimulus("p1_ld0",  1, 1, 8'h22, 3'b000, 3'b111, 3'b000, ev(S_LD,  3'b010, 3'b000, 3'b000));
        applyStimulus("p1_ld1",  1, 1, 8'h33, 3'b000, 3'b111, 3'b000, ev(S_LD,  3'b010, 3'b000, 3'b000));
        applyStimulus("p1_ld2",  1, 0, 8'h44, 3'b000, 3'b111, 3'b000, ev(S_LD,  3'b010, 3'b000, 3'b000));
        applyStimulus("p1_lp",   1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_LP,  3'b010, 3'b000, 3'b000));
        applyStimulus("p1_cpe",  1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_CPE, 3'b000, 3'b000, 3'b000));
        applyStimulus("p1_idle", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_DA,  3'b000, 3'b000, 3'b000));

        applyStimulus("f_hdr",   1, 1, 8'h05, 3'b000, 3'b111, 3'b000, ev(S_DA,   3'b000, 3'b000, 3'b000));
        applyStimulus("f_lfd",   1, 1, 8'h10, 3'b000, 3'b111, 3'b000, ev(S_LFD,  3'b010, 3'b000, 3'b000));
        applyStimulus("f_ld0",   1, 1, 8'h20, 3'b000, 3'b111, 3'b000, ev(S_LD,   3'b010, 3'b000, 3'b000));
        applyStimulus("f_ld1",   1, 1, 8'h30, 3'b010, 3'b111, 3'b000, ev(S_LD,   3'b000, 3'b000, 3'b000));
        for (int k = 0; k < 3; k++)
            applyStimulus("f_full", 1, 1, 8'h30, 3'b010, 3'b111, 3'b000, ev(S_FULL, 3'b000, 3'b000, 3'b000));
        applyStimulus("f_rel",   1, 1, 8'h30, 3'b000, 3'b111, 3'b000, ev(S_FULL, 3'b000, 3'b000, 3'b000));
        applyStimulus("f_laf",   1, 1, 8'h30, 3'b000, 3'b111, 3'b000, ev(S_LAF,  3'b010, 3'b000, 3'b000));
        applyStimulus("f_ld2",   1, 1, 8'h40, 3'b000, 3'b111, 3'b000, ev(S_LD,   3'b010, 3'b000, 3'b000));
        applyStimulus("f_ld3",   1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_LD,   3'b010, 3'b000, 3'b000));
        applyStimulus("f_lp",    1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_LP,   3'b010, 3'b000, 3'b000));
        applyStimulus("f_cpe",   1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_CPE,  3'b000, 3'b000, 3'b000));
        applyStimulus("f_idle",  1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_DA,   3'b000, 3'b000, 3'b000));

        applyStimulus("w_hdr",   1, 1, 8'h06, 3'b000, 3'b011, 3'b000, ev(S_DA,  3'b000, 3'b000, 3'b100));
        applyStimulus("w_wait0", 1, 1, 8'h06, 3'b000, 3'b011, 3'b000, ev(S_WTE, 3'b000, 3'b000, 3'b100));
        applyStimulus("w_wait1", 1, 1, 8'h06, 3'b000, 3'b011, 3'b000, ev(S_WTE, 3'b000, 3'b000, 3'b100));
        applyStimulus("w_empty", 1, 1, 8'h06, 3'b000, 3'b111, 3'b000, ev(S_WTE, 3'b000, 3'b000, 3'b000));
        applyStimulus("w_lfd",   1, 1, 8'h55, 3'b000, 3'b111, 3'b000, ev(S_LFD, 3'b100, 3'b000, 3'b000));
        applyStimulus("w_ld",    1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_LD,  3'b100, 3'b000, 3'b000));
        applyStimulus("w_lp",    1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_LP,  3'b100, 3'b000, 3'b000));
        applyStimulus("w_cpe",   1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_CPE, 3'b000, 3'b000, 3'b000));
        applyStimulus("w_idle",  1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_DA,  3'b000, 3'b000, 3'b000));

        for (int k = 1; k <= 30; k++)
            applyStimulus("to_count", 1, 0, 8'h00, 3'b000, 3'b110, 3'b000, ev(S_DA, 3'b000, 3'b000, 3'b001));
        applyStimulus("to_pulse", 1, 0, 8'h00, 3'b000, 3'b110, 3'b000, ev(S_DA, 3'b000, 3'b001, 3'b001));
        applyStimulus("to_clear", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_DA, 3'b000, 3'b000, 3'b000));

        for (int k = 1; k <= 19; k++)
            applyStimulus("rd_pre", 1, 0, 8'h00, 3'b000, 3'b110, 3'b000, ev(S_DA, 3'b000, 3'b000, 3'b001));
        applyStimulus("rd_pulse", 1, 0, 8'h00, 3'b000, 3'b110, 3'b001, ev(S_DA, 3'b000, 3'b000, 3'b001));
        for (int k = 1; k <= 30; k++)
            applyStimulus("rd_post", 1, 0, 8'h00, 3'b000, 3'b110, 3'b000, ev(S_DA, 3'b000, 3'b000, 3'b001));
        applyStimulus("rd_sr", 1, 0, 8'h00, 3'b000, 3'b110, 3'b000, ev(S_DA, 3'b000, 3'b001, 3'b001));
        applyStimulus("rd_clr", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_DA, 3'b000, 3'b000, 3'b000));

        applyStimulus("ab_hdr", 1, 1, 8'h04, 3'b000, 3'b111, 3'b000, ev(S_DA,  3'b000, 3'b000, 3'b000));
        applyStimulus("ab_lfd", 1, 1, 8'h60, 3'b000, 3'b110, 3'b000, ev(S_LFD, 3'b001, 3'b000, 3'b001));
        for (int k = 2; k <= 30; k++)
            applyStimulus("ab_ld", 1, 1, 8'h70, 3'b000, 3'b110, 3'b000, ev(S_LD, 3'b001, 3'b000, 3'b001));
        applyStimulus("ab_sr",   1, 0, 8'h00, 3'b000, 3'b110, 3'b000, ev(S_LD, 3'b001, 3'b001, 3'b001));
        applyStimulus("ab_idle", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_DA, 3'b000, 3'b000, 3'b000));

`ifdef ROUTER_ADDR_ERR_EN
        applyStimulus("bad_hdr",  1, 1, 8'h03, 3'b000, 3'b111, 3'b000, ev(S_DA,   3'b000, 3'b000, 3'b000));
        applyStimulus("bad_drop", 1, 1, 8'h03, 3'b000, 3'b111, 3'b000, ev(S_DROP, 3'b000, 3'b000, 3'b000, 1'b1));
        applyStimulus("bad_end",  1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_DROP, 3'b000, 3'b000, 3'b000));
        applyStimulus("bad_idle", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_DA,   3'b000, 3'b000, 3'b000));
`else
        applyStimulus("bad_hdr",  1, 1, 8'h03, 3'b000, 3'b111, 3'b000, ev(S_DA, 3'b000, 3'b000, 3'b000));
        applyStimulus("bad_hold", 1, 1, 8'h03, 3'b000, 3'b111, 3'b000, ev(S_DA, 3'b000, 3'b000, 3'b000));
        applyStimulus("bad_idle", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, ev(S_DA, 3'b000, 3'b000, 3'b000));
`endif

        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
